reg_op_sequencer: RTL
=====================

Name: reg_op_sequencer

Overview:
- Byte-stream micro-sequencer directly upstream of the 6 x 8-bit register block.
- Accepts instruction bytes over a valid/ready input and decodes them.
- Drives the register block's write_enable, read_enable, src_reg, dst_reg and input_bus; takes its output_bus, r1 and r2 back.
- Performs ADD/SUB of r1/r2 internally, and emits OUT results on a valid/ready output.

Parameters:
DATA_W, 8, data/register width
REG_AW, 3, register index width
NUM_REGS, 6, legal register indices 0..NUM_REGS-1

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
in_data  in  8  instruction byte
in_valid  in  1  in_data valid
in_ready  out  1  sequencer accepts byte
rb_data  in  8  register block output_bus
r1  in  8  register block r1
r2  in  8  register block r2
rb_we  out  1  to write_enable
rb_re  out  1  to read_enable
rb_src  out  3  to src_reg
rb_dst  out  3  to dst_reg
rb_wdata  out  8  to input_bus
out_data  out  8  OUT result
out_valid  out  1  out_data valid
out_ready  in  1  consumer accepts out_data
flag_c  out  1  carry (ADD) / borrow (SUB), sticky until next ADD/SUB
busy  out  1  state != FETCH
err  out  1  sticky error

Behaviour:
- Reset: asynchronous, active-high (rst); clock clk.
  - Reset state is FETCH.
  - All outputs 0 except in_ready=1.
  - Reset mid-instruction discards the partial instruction with no register write.
- Byte transfer occurs on a rising edge with in_valid & in_ready.
- Output transfer occurs on a rising edge with out_valid & out_ready.
- Opcode byte: [7:5] op, [4:3] ignored, [2:0] reg (rd, or rs for OUT).
  - 0 NOP: 1 byte.
  - 1 LDI rd: second byte = imm.
  - 2 MOV rd: second byte [2:0] = rs.
  - 3 ADD rd: rd = r1+r2.
  - 4 SUB rd: rd = r1-r2.
  - 5 OUT rs.
  - 6, 7 illegal.
- States: FETCH, OPERAND, READ, CAPT, WRITE, EMIT.
- FETCH: in_ready=1. On byte accept:
  - NOP stays in FETCH, so back-to-back NOPs take 1 cycle each.
  - LDI/MOV -> OPERAND.
  - ADD/SUB -> WRITE.
  - OUT -> READ.
  - Illegal op -> err=1, stay in FETCH.
- OPERAND: in_ready=1. On accept:
  - LDI -> WRITE with rb_wdata=imm.
  - MOV -> READ with rb_src=operand[2:0].
- READ: rb_re=1 for exactly one cycle. Next state is WRITE (MOV) or CAPT (OUT).
- CAPT: rb_re=0. At the cycle-end edge, out_data<=rb_data and out_valid<=1, then -> EMIT.
- EMIT: out_data/out_valid held stable until out_ready, then -> FETCH. No new byte is accepted while in EMIT.
- WRITE: rb_we=1 for exactly one cycle with rb_dst=rd, then -> FETCH. rb_wdata by op:
  - LDI: latched imm.
  - MOV: rb_data, passed through combinationally.
  - ADD/SUB: sum/difference of r1/r2 sampled in this cycle; flag_c updates on the same edge (carry out, or borrow = r1<r2).
- Arithmetic is 8-bit wrap-around; the 9th bit goes to flag_c.
- rb_we and rb_re are never both high in one cycle.
- rb_src/rb_dst/rb_wdata are don't-care when their enable is low; they are driven 0.
- Latencies, measured from the accepting edge of the final byte:
  - LDI/ADD/SUB: write commits on the 2nd edge.
  - MOV: write commits on the 3rd edge.
  - OUT: out_valid high after the 3rd edge.
- Illegal register index (>=NUM_REGS) in rd or rs:
  - err=1 and the instruction is discarded with no rb_we and no rb_re.
  - A 2-byte instruction still consumes its operand byte, keeping the stream aligned.
- err is cleared only by rst.
- MOV rd==rs is legal: the register is rewritten with its own value.

Decomposition:
- Shared package reg_seq_pkg:
  - Opcode constants OP_NOP..OP_OUT.
  - State encoding.
  - NUM_REGS and DATA_W defaults.
- One sub-module, reg_seq_alu: combinational add/sub of two DATA_W operands, producing result plus carry/borrow.

Test Plan:
- Reset, then bytes 0x22,0x5A (LDI r2,0x5A) -> exactly one rb_we pulse with rb_dst=2, rb_wdata=0x5A on the 2nd edge after the imm accept; in_ready=0 during WRITE.
- LDI r1=0xF0, LDI r2=0x20, then byte 0x63 (ADD r3) -> write 0x10 to r3 with flag_c=1. Then SUB r4 with r1=0x10, r2=0x20 -> write 0xF0 with flag_c=1.
- MOV r5,r2 (0x45,0x02) with rb_data model returning 0x5A after the read -> rb_re pulse with src=2, then rb_we with dst=5, wdata=0x5A.
- OUT r2 (0xA2) with out_ready held low 5 cycles -> out_valid high with out_data=0x5A stable throughout; in_ready=0 until out_ready is seen; back to FETCH.
- 0xC0 (illegal op), then LDI r6 (0x26,0x11) -> err=1, no rb_we; both bytes of the LDI are consumed; a following LDI r0 executes normally.
- Assert rst during OPERAND of an LDI -> no write; all outputs at reset values; next opcode is decoded cleanly.

Source files
------------

// File: rtl/reg_seq_pkg.sv
// Shared definitions for the register-block micro-sequencer: opcodes, FSM states and
// default sizes.
package reg_seq_pkg;

  localparam int unsigned DefDataW   = 8;
  localparam int unsigned DefRegAw   = 3;
  localparam int unsigned DefNumRegs = 6;

  localparam logic [2:0] OP_NOP = 3'd0;
  localparam logic [2:0] OP_LDI = 3'd1;
  localparam logic [2:0] OP_MOV = 3'd2;
  localparam logic [2:0] OP_ADD = 3'd3;
  localparam logic [2:0] OP_SUB = 3'd4;
  localparam logic [2:0] OP_OUT = 3'd5;

  typedef enum logic [2:0] {
    StFetch,
    StOperand,
    StRead,
    StCapt,
    StWrite,
    StEmit
  } state_e;

endpackage

// File: rtl/reg_seq_alu.sv
// Combinational add/subtract; cb_o is the carry out for ADD and the borrow (a < b) for SUB.
module reg_seq_alu #(
  parameter int unsigned DATA_W = 8
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic              sub_i,
  output logic [DATA_W-1:0] res_o,
  output logic              cb_o
);

  always_comb begin
    // The extra top bit of the widened result is the carry, or the borrow on wrap.
    if (sub_i) begin
      {cb_o, res_o} = {1'b0, a_i} - {1'b0, b_i};
    end else begin
      {cb_o, res_o} = {1'b0, a_i} + {1'b0, b_i};
    end
  end

endmodule

// File: rtl/reg_op_sequencer.sv
// Byte-stream micro-sequencer: decodes instruction bytes and drives the 6 x 8-bit register
// block, doing ADD/SUB of r1/r2 internally and emitting OUT results on a valid/ready port.
module reg_op_sequencer
  import reg_seq_pkg::*;
#(
  parameter int unsigned DATA_W   = DefDataW,
  parameter int unsigned REG_AW   = DefRegAw,
  parameter int unsigned NUM_REGS = DefNumRegs
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] rb_data_i,
  input  logic [DATA_W-1:0] r1_i,
  input  logic [DATA_W-1:0] r2_i,
  output logic              rb_we_o,
  output logic              rb_re_o,
  output logic [REG_AW-1:0] rb_src_o,
  output logic [REG_AW-1:0] rb_dst_o,
  output logic [DATA_W-1:0] rb_wdata_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic              flag_c_o,
  output logic              busy_o,
  output logic              err_o
);

  state_e            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic [REG_AW-1:0] rs_q, rs_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              flag_c_q, flag_c_d;
  logic              err_q, err_d;

  logic              in_fire;
  logic [2:0]        byte_op;
  logic [REG_AW-1:0] byte_reg;
  logic [DATA_W-1:0] alu_res;
  logic              alu_cb;

  function automatic logic reg_ok(input logic [REG_AW-1:0] r);
    return 32'(r) < NUM_REGS;
  endfunction

  assign in_ready_o = (state_q == StFetch) || (state_q == StOperand);
  assign in_fire    = in_valid_i && in_ready_o;
  assign byte_op    = in_data_i[DATA_W-1 -: 3];
  assign byte_reg   = in_data_i[REG_AW-1:0];

  reg_seq_alu #(
    .DATA_W(DATA_W)
  ) u_alu (
    .a_i  (r1_i),
    .b_i  (r2_i),
    .sub_i(op_q == OP_SUB),
    .res_o(alu_res),
    .cb_o (alu_cb)
  );

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    rd_d        = rd_q;
    rs_d        = rs_q;
    imm_d       = imm_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    flag_c_d    = flag_c_q;
    err_d       = err_q;
    rb_we_o     = 1'b0;
    rb_re_o     = 1'b0;
    rb_src_o    = '0;
    rb_dst_o    = '0;
    rb_wdata_o  = '0;

    unique case (state_q)
      StFetch: begin
        if (in_fire) begin
          op_d = byte_op;
          rd_d = byte_reg;
          rs_d = byte_reg;
          case (byte_op)
            OP_NOP: ;
            OP_LDI, OP_MOV: state_d = StOperand;
            OP_ADD, OP_SUB: begin
              if (reg_ok(byte_reg)) state_d = StWrite;
              else                  err_d   = 1'b1;
            end
            OP_OUT: begin
              if (reg_ok(byte_reg)) state_d = StRead;
              else                  err_d   = 1'b1;
            end
            default: err_d = 1'b1;
          endcase
        end
      end
      StOperand: begin
        // A bad register still consumes the operand so the byte stream stays aligned.
        if (in_fire) begin
          imm_d = in_data_i;
          rs_d  = byte_reg;
          if (!reg_ok(rd_q) || ((op_q == OP_MOV) && !reg_ok(byte_reg))) begin
            err_d   = 1'b1;
            state_d = StFetch;
          end else begin
            state_d = (op_q == OP_MOV) ? StRead : StWrite;
          end
        end
      end
      StRead: begin
        rb_re_o  = 1'b1;
        rb_src_o = rs_q;
        state_d  = (op_q == OP_OUT) ? StCapt : StWrite;
      end
      StCapt: begin
        out_data_d  = rb_data_i;
        out_valid_d = 1'b1;
        state_d     = StEmit;
      end
      StEmit: begin
        if (out_ready_i) begin
          out_valid_d = 1'b0;
          state_d     = StFetch;
        end
      end
      StWrite: begin
        rb_we_o  = 1'b1;
        rb_dst_o = rd_q;
        case (op_q)
          OP_LDI: rb_wdata_o = imm_q;
          OP_MOV: rb_wdata_o = rb_data_i;
          default: begin
            rb_wdata_o = alu_res;
            flag_c_d   = alu_cb;
          end
        endcase
        state_d = StFetch;
      end
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StFetch;
      op_q        <= OP_NOP;
      rd_q        <= '0;
      rs_q        <= '0;
      imm_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      flag_c_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      rd_q        <= rd_d;
      rs_q        <= rs_d;
      imm_q       <= imm_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      flag_c_q    <= flag_c_d;
      err_q       <= err_d;
    end
  end

  assign out_data_o  = out_data_q;
  assign out_valid_o = out_valid_q;
  assign flag_c_o    = flag_c_q;
  assign err_o       = err_q;
  assign busy_o      = (state_q != StFetch);

endmodule
